// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin grant/release arbiter driving a shared 2:1 mux with a registered output.
// Optional MUX_ARB_TIMEOUT_EN preempts a grant after MAX_HOLD cycles when the other side is waiting.
module mux_share_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] f,
    output logic             f_valid
);
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
    state_t state, nxt;
    logic last_grant;
    logic pre_a, pre_b;
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("MAX_HOLD must be 2 or more");
    end
`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;
    logic expire;
    assign expire = hold_cnt == HW'(MAX_HOLD - 1);
    assign pre_a  = (state == GRANT_A) & expire & req_b;
    assign pre_b  = (state == GRANT_B) & expire & req_a;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else
            hold_cnt <= nxt != state ? '0 :
                        (state != IDLE && hold_cnt != HW'(MAX_HOLD)) ? hold_cnt + 1'b1 : hold_cnt;
    end
`else
    assign pre_a = 1'b0;
    assign pre_b = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (req_a & req_b) ? (last_grant ? GRANT_A : GRANT_B) :
                           req_a ? GRANT_A : req_b ? GRANT_B : IDLE;
            GRANT_A: nxt = (req_a & ~pre_a) ? GRANT_A : req_b ? GRANT_B : IDLE;
            GRANT_B: nxt = (req_b & ~pre_b) ? GRANT_B : req_a ? GRANT_A : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // f samples through the select that was live during the grant cycle, so it lags gnt by one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            sel        <= 1'b0;
            f          <= '0;
            f_valid    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= nxt;
            gnt_a      <= nxt == GRANT_A;
            gnt_b      <= nxt == GRANT_B;
            sel        <= nxt == GRANT_B ? 1'b1 : nxt == GRANT_A ? 1'b0 : sel;
            last_grant <= nxt == IDLE ? last_grant : nxt == GRANT_B;
            f_valid    <= state != IDLE;
            f          <= state == IDLE ? f : sel ? b : a;
        end
    end
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed self-checking bench for mux_share_arbiter.
module tb_mux_share_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic gnt_a, gnt_b, sel, f_valid;
    logic [3:0] f;
    logic [7:0] o;
    int errors = 0;
    int checks = 0;

    mux_share_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .f(f), .f_valid(f_valid)
    );

    assign o = {gnt_a, gnt_b, sel, f_valid, f};
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o !== 8'b0000_0000) begin
                errors++;
                $display("FAIL reset[%0d] got %b want 00000000", i, o);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o !== 8'b0000_0000) begin
                errors++;
                $display("FAIL idle[%0d] got %b want 00000000", i, o);
            end
        end
    endtask

    task automatic test_single_a();
        logic [7:0] exp [6];
        exp = '{8'b1000_0000, 8'b1001_1011, 8'b1001_1011, 8'b1001_1011, 8'b0001_1011, 8'b0000_1011};
        a = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            req_a = i < 4;
            tick();
            checks++;
            if (o !== exp[i]) begin
                errors++;
                $display("FAIL single_a[%0d] got %b want %b", i, o, exp[i]);
            end
        end
    endtask

    task automatic test_tie();
        logic [7:0] exp [6];
        exp = '{8'b1000_0000, 8'b1001_0000, 8'b0111_0000, 8'b0111_1000, 8'b0011_1000, 8'b0010_1000};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a = 4'b0000;
        b = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            req_a = i < 2;
            req_b = i < 4;
            tick();
            checks++;
            if (o !== exp[i]) begin
                errors++;
                $display("FAIL tie[%0d] got %b want %b", i, o, exp[i]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [1:0] win;
        logic [1:0] exp;
        for (int r = 0; r < 4; r++) begin
            win = r % 2 == 0 ? 2'b10 : 2'b01;
            for (int i = 0; i < 4; i++) begin
                req_a = i < 2;
                req_b = i < 2;
                tick();
                exp = i < 2 ? win : 2'b00;
                checks++;
                if ({gnt_a, gnt_b} !== exp) begin
                    errors++;
                    $display("FAIL rr[%0d.%0d] got gnt=%b want %b", r, i, {gnt_a, gnt_b}, exp);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [1:0] exp;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
`ifdef MUX_ARB_TIMEOUT_EN
            exp = (i < 8 || i >= 16) ? 2'b10 : 2'b01;
`else
            exp = 2'b10;
`endif
            checks++;
            if ({gnt_a, gnt_b} !== exp) begin
                errors++;
                $display("FAIL hold[%0d] got gnt=%b want %b", i, {gnt_a, gnt_b}, exp);
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tick();
        checks++;
        if ({gnt_a, gnt_b} !== 2'b00) begin
            errors++;
            $display("FAIL hold_release got gnt=%b want 00", {gnt_a, gnt_b});
        end
    endtask

    task automatic test_reset_mid();
        b = 4'b0110;
        req_b = 1'b1;
        tick();
        tick();
        checks++;
        if (o !== 8'b0111_0110) begin
            errors++;
            $display("FAIL pre_reset got %b want 01110110", o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o !== 8'b0000_0000) begin
            errors++;
            $display("FAIL async_reset got %b want 00000000", o);
        end
        req_b = 1'b0;
        tick();
        rst_n = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        checks++;
        if (o !== 8'b1000_0000) begin
            errors++;
            $display("FAIL post_reset_tie got %b want 10000000", o);
        end
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_tie();
        test_fairness();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
